// File: rtl/ps2_scan_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module : ps2_scan_receiver_pkg
// Purpose: Shared PS/2 frame constants and the frame-validity helper used by
//          the scan-code receiver.
// Ports  : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package ps2_scan_receiver_pkg;

    // 11-bit frame, LSB first: start, d0..d7, odd parity, stop
    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_BIT_START  = 0;
    localparam int PS2_BIT_PAR    = 9;
    localparam int PS2_BIT_STOP   = 10;
    localparam int PS2_CNT_W      = 4;

    // shift holds start..parity; the stop bit is taken live from the data
    // synchroniser because it is never shifted in.
    function automatic logic ps2_frame_ok(input logic [PS2_BIT_PAR:0] shift,
                                          input logic                 stop_bit);
        return (shift[PS2_BIT_START] == 1'b0) && stop_bit &&
               (^shift[PS2_BIT_PAR:1]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : ps2_sync_fifo
// Purpose: Single-clock show-ahead FIFO. head_o always presents the oldest
//          entry; simultaneous push and pop are both honoured, even when full.
// Ports  : clk_i    - clock
//          rstn_i   - synchronous active-low reset (clears pointers)
//          push_i   - write wdata_i (ignored when full unless popping)
//          pop_i    - consume head (ignored when empty)
//          wdata_i  - write data
//          full_o   - FIFO full
//          empty_o  - FIFO empty
//          head_o   - oldest entry (undefined content while empty)
// Revision: 1.0 - initial release
// ============================================================================
module ps2_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // When full, a same-cycle pop frees the slot being written.
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/ps2_scan_receiver.sv
`default_nettype none
// ============================================================================
// Module : ps2_scan_receiver
// Purpose: Receives PS/2 keyboard frames, validates start/odd-parity/stop and
//          queues good scan codes in a show-ahead FIFO feeding the hex decoders.
// Ports  : clk_i       - system clock (sole domain)
//          clrn_i      - synchronous active-low reset
//          ps2_clk_i   - raw PS/2 clock (asynchronous)
//          ps2_data_i  - raw PS/2 data (asynchronous)
//          pop_i       - consume head entry (ignored when ready_o=0)
//          clr_err_i   - clear sticky flags
//          data_o      - FIFO head scan code, 8'h00 when empty
//          ready_o     - FIFO non-empty
//          overflow_o  - sticky: good frame dropped, FIFO full
//          frame_err_o - sticky: bad frame dropped
// Revision: 1.0 - initial release
// ============================================================================
module ps2_scan_receiver
    import ps2_scan_receiver_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 8192
) (
    input  logic       clk_i,
    input  logic       clrn_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    input  logic       pop_i,
    input  logic       clr_err_i,
    output logic [7:0] data_o,
    output logic       ready_o,
    output logic       overflow_o,
    output logic       frame_err_o
);
    localparam int                   TW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0]        TO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0]        TO_ONE   = TW'(1);
    localparam logic [PS2_CNT_W-1:0] CNT_STOP = PS2_CNT_W'(PS2_BIT_STOP);
    localparam logic [PS2_CNT_W-1:0] CNT_ONE  = PS2_CNT_W'(1);

    logic [2:0]             ps2c_sync_q;
    logic [1:0]             ps2d_sync_q;
    logic [PS2_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [PS2_BIT_PAR:0]   shift_q, shift_d;
    logic [TW-1:0]          to_ctr_q, to_ctr_d;
    logic                   overflow_q, overflow_d;
    logic                   frame_err_q, frame_err_d;

    logic       fall, data_s, frame_done, frame_good, frame_bad;
    logic       fifo_full, fifo_empty, fifo_push, fifo_pop, drop_full;
    logic [7:0] fifo_head;

    // Newest sample enters at bit 0; a fall is old-high followed by new-low.
    assign fall   = (ps2c_sync_q[2:1] == 2'b10);
    assign data_s = ps2d_sync_q[1];

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        to_ctr_d   = to_ctr_q;
        frame_done = 1'b0;
        if (fall) begin
            to_ctr_d = '0;
            if (bit_cnt_q < CNT_STOP) begin
                shift_d[bit_cnt_q] = data_s;
                bit_cnt_d          = bit_cnt_q + CNT_ONE;
            end else begin
                bit_cnt_d  = '0;
                frame_done = 1'b1;
            end
        end else if (bit_cnt_q == '0) begin
            to_ctr_d = '0;
        end else if (to_ctr_q == TO_LAST) begin
            // Stalled mid-frame: resync silently, partial frame discarded.
            bit_cnt_d = '0;
            to_ctr_d  = '0;
        end else begin
            to_ctr_d = to_ctr_q + TO_ONE;
        end
    end

    assign frame_good = frame_done && ps2_frame_ok(shift_q, data_s);
    assign frame_bad  = frame_done && !frame_good;
    assign ready_o    = !fifo_empty;
    assign fifo_pop   = pop_i && ready_o;
    assign fifo_push  = frame_good && (!fifo_full || fifo_pop);
    assign drop_full  = frame_good && fifo_full && !fifo_pop;

    // Set events take priority over clr_err in the same cycle.
    assign overflow_d  = drop_full ? 1'b1 : (clr_err_i ? 1'b0 : overflow_q);
    assign frame_err_d = frame_bad ? 1'b1 : (clr_err_i ? 1'b0 : frame_err_q);

    always_ff @(posedge clk_i) begin
        if (!clrn_i) begin
            ps2c_sync_q <= 3'b111;
            ps2d_sync_q <= 2'b11;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            to_ctr_q    <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            ps2c_sync_q <= {ps2c_sync_q[1:0], ps2_clk_i};
            ps2d_sync_q <= {ps2d_sync_q[0], ps2_data_i};
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            to_ctr_q    <= to_ctr_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    ps2_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (clrn_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (shift_q[8:1]),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign data_o      = ready_o ? fifo_head : 8'h00;
    assign overflow_o  = overflow_q;
    assign frame_err_o = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scan_receiver.sv
`default_nettype none
// ============================================================================
// Module : tb_ps2_scan_receiver
// Purpose: Self-checking bench for ps2_scan_receiver. A queue-based model of
//          the scan-code FIFO and sticky flags supplies expected values.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ps2_scan_receiver;
    localparam int DEPTH = 8;
    localparam int TO    = 512;
    localparam int HALF  = 20;   // clk cycles per PS/2 half period

    logic       clk = 1'b0;
    logic       clrn, ps2_clk, ps2_data, pop, clr_err;
    logic [7:0] data;
    logic       ready, overflow, frame_err;

    int checks = 0;
    int errors = 0;

    byte unsigned mq[$];
    bit           m_ovf, m_ferr;

    always #5 clk = ~clk;

    ps2_scan_receiver #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i       (clk),
        .clrn_i      (clrn),
        .ps2_clk_i   (ps2_clk),
        .ps2_data_i  (ps2_data),
        .pop_i       (pop),
        .clr_err_i   (clr_err),
        .data_o      (data),
        .ready_o     (ready),
        .overflow_o  (overflow),
        .frame_err_o (frame_err)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic bad);
        return {1'b1, (~^d) ^ bad, d, 1'b0};
    endfunction

    function automatic void model_frame(input logic [7:0] d, input logic bad);
        if (bad) m_ferr = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(d);
        else m_ovf = 1'b1;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic bad);
        logic [10:0] f;
        f = make_frame(d, bad);
        for (int i = 0; i < 11; i++) ps2_bit(f[i]);
        tick(4);
        model_frame(d, bad);
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick(1);
        pop = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
    endtask

    task automatic do_clr();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic test_reset();
        clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; pop = 1'b0; clr_err = 1'b0;
        tick(3);
        checks++; if (ready !== 1'b0)     begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
        checks++; if (data !== 8'h00)     begin errors++; $display("FAIL reset_data got %h exp 00", data); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
        clrn = 1'b1;
        mq.delete(); m_ovf = 1'b0; m_ferr = 1'b0;
        tick(2);
    endtask

    task automatic test_single_latency();
        logic [10:0] f;
        f = make_frame(8'h1C, 1'b0);
        for (int i = 0; i < 10; i++) ps2_bit(f[i]);
        ps2_data = f[10];
        tick(HALF);
        ps2_clk = 1'b0;
        tick(2);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL lat_early got %b exp 0", ready); end
        tick(2);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL lat_ready got %b exp 1", ready); end
        checks++; if (data !== 8'h1C) begin errors++; $display("FAIL lat_data got %h exp 1c", data); end
        tick(HALF - 4);
        ps2_clk = 1'b1;
        tick(HALF);
        model_frame(8'h1C, 1'b0);
        do_pop();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL pop_ready got %b exp 0", ready); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL pop_data got %h exp 00", data); end
    endtask

    task automatic test_sequence();
        byte unsigned seq[4] = '{8'hF0, 8'h1C, 8'hE0, 8'h75};
        foreach (seq[i]) send_frame(seq[i], 1'b0);
        checks++; if (data !== 8'hF0) begin errors++; $display("FAIL seq_head got %h exp f0", data); end
        foreach (seq[i]) begin
            checks++;
            if (data !== seq[i] || ready !== 1'b1) begin
                errors++; $display("FAIL seq_pop%0d got %h/%b exp %h/1", i, data, ready, seq[i]);
            end
            do_pop();
        end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL seq_empty got %b exp 0", ready); end
    endtask

    task automatic test_overflow();
        logic [7:0]  d;
        logic [10:0] f;
        for (int i = 0; i < 9; i++) send_frame(8'($urandom), 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
        checks++; if (data !== mq[0]) begin errors++; $display("FAIL ovf_head got %h exp %h", data, mq[0]); end
        // 10th frame with a pop landing in the push cycle
        d = 8'($urandom);
        f = make_frame(d, 1'b0);
        for (int i = 0; i < 10; i++) ps2_bit(f[i]);
        ps2_data = f[10];
        tick(HALF);
        ps2_clk = 1'b0;
        tick(2);
        pop = 1'b1;
        tick(1);
        pop = 1'b0;
        void'(mq.pop_front());
        mq.push_back(d);
        tick(HALF - 3);
        ps2_clk = 1'b1;
        tick(HALF);
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (data !== mq[0] || ready !== 1'b1) begin
                errors++; $display("FAIL ovf_drain%0d got %h/%b exp %h/1", i, data, ready, mq[0]);
            end
            do_pop();
        end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b exp 0", ready); end
        do_clr();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", overflow); end
    endtask

    task automatic test_parity_err();
        send_frame(8'h1C, 1'b1);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL par_err got %b exp 1", frame_err); end
        checks++; if (ready !== 1'b0)     begin errors++; $display("FAIL par_ready got %b exp 0", ready); end
        do_clr();
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL par_clr got %b exp 0", frame_err); end
    endtask

    task automatic test_clr_collision();
        logic [10:0] f;
        f = make_frame(8'h3A, 1'b1);
        for (int i = 0; i < 10; i++) ps2_bit(f[i]);
        ps2_data = f[10];
        tick(HALF);
        ps2_clk = 1'b0;
        tick(2);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        tick(HALF - 3);
        ps2_clk = 1'b1;
        tick(HALF);
        m_ferr = 1'b1;
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL clr_collide got %b exp 1", frame_err); end
        do_clr();
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 5; i++) ps2_bit(1'b0);
        tick(TO + 100);
        send_frame(8'h29, 1'b0);
        checks++; if (data !== 8'h29 || ready !== 1'b1) begin errors++; $display("FAIL to_data got %h/%b exp 29/1", data, ready); end
        checks++; if (overflow !== 1'b0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL to_flags got %b%b exp 00", overflow, frame_err);
        end
        do_pop();
    endtask

    task automatic test_reset_midframe();
        logic [10:0] f;
        f = make_frame(8'hC3, 1'b0);
        for (int i = 0; i < 6; i++) ps2_bit(f[i]);
        ps2_data = f[6];
        tick(HALF / 2);
        clrn = 1'b0;
        tick(2);
        clrn = 1'b1;
        mq.delete(); m_ovf = 1'b0; m_ferr = 1'b0;
        tick(HALF);
        send_frame(8'h5A, 1'b0);
        checks++; if (data !== 8'h5A || ready !== 1'b1) begin errors++; $display("FAIL rst_mid got %h/%b exp 5a/1", data, ready); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_mid_ferr got %b exp 0", frame_err); end
        do_pop();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_mid_only got %b exp 0", ready); end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       bad;
        int         npop;
        for (int it = 0; it < 16; it++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            send_frame(d, bad);
            checks++;
            if (ready !== (mq.size() != 0) || data !== ((mq.size() != 0) ? mq[0] : 8'h00) ||
                overflow !== m_ovf || frame_err !== m_ferr) begin
                errors++;
                $display("FAIL rand%0d got r%b d%h o%b f%b exp r%b d%h o%b f%b", it, ready, data,
                         overflow, frame_err, mq.size() != 0, (mq.size() != 0) ? mq[0] : 8'h00, m_ovf, m_ferr);
            end
            npop = (it < 10) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 2));
            for (int k = 0; k < npop; k++) begin
                if (mq.size() != 0) begin
                    checks++;
                    if (data !== mq[0]) begin errors++; $display("FAIL rand_pop%0d got %h exp %h", it, data, mq[0]); end
                    do_pop();
                end
            end
            if ($urandom_range(0, 5) == 0) do_clr();
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_latency();
        test_sequence();
        test_overflow();
        test_parity_err();
        test_clr_collision();
        test_timeout();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
